apb_master_bridge: RTL
======================

// Module: apb_master_bridge
// PURPOSE
//  Parametrised APB4 master. Accepts read/write commands on a valid/ready port and buffers them in a small FIFO.
//  Decodes the slave select from the upper address bits and runs SETUP/ACCESS phases with wait states.
//  Returns one response per command. Sits between the testbench/CPU-side command agent and the APB slave fabric.
// PARAMETERS
//  ADDR_WIDTH      32  PADDR/cmd_addr width
//  DATA_WIDTH      32  PWDATA/PRDATA width; multiple of 8; STRB_W = DATA_WIDTH/8
//  NUM_SLAVES      4   PSEL width; slave index = cmd_addr[ADDR_WIDTH-1 -: SLV_BITS], SLV_BITS=$clog2(NUM_SLAVES); NUM_SLAVES==1 -> no decode
//  CMD_DEPTH       4   command FIFO depth; power of 2, >=2
//  TIMEOUT_CYCLES  16  ACCESS-phase watchdog limit (APB_TIMEOUT_EN only)
// PORTS
//  PCLK        in   1           clock
//  PRESET      in   1           asynchronous reset, active-high
//  cmd_valid   in   1           command present
//  cmd_ready   out  1           FIFO not full
//  cmd_write   in   1           1 write, 0 read
//  cmd_addr    in   ADDR_WIDTH  target address
//  cmd_wdata   in   DATA_WIDTH  write data
//  cmd_strb    in   STRB_W      byte strobes (writes)
//  cmd_prot    in   3           PPROT value
//  rsp_valid   out  1           response held
//  rsp_ready   in   1           response consumed
//  rsp_rdata   out  DATA_WIDTH  read data; 0 for writes/errors
//  rsp_err     out  1           PSLVERR, decode error or timeout
//  PSEL        out  NUM_SLAVES  one-hot slave select
//  PENABLE     out  1           ACCESS phase
//  PWRITE      out  1
//  PADDR       out  ADDR_WIDTH
//  PWDATA      out  DATA_WIDTH
//  PSTRB       out  STRB_W      forced 0 on reads
//  PPROT       out  3
//  PREADY      in   1           from selected slave (externally muxed)
//  PRDATA      in   DATA_WIDTH
//  PSLVERR     in   1           sampled only when PENABLE&PREADY
// BEHAVIOUR
//  Reset (async, any state): FSM IDLE, FIFO emptied, all outputs 0; cmd_ready=1 on the first edge after release.
//  Push on cmd_valid&cmd_ready. Pop when IDLE->SETUP. Push into a full FIFO is impossible: cmd_ready=0.
//    Simultaneous push and pop when full is not allowed.
//  FSM IDLE: go to SETUP when FIFO is non-empty and !rsp_valid. Launch latency from an idle bridge is 2 cycles after the push.
//  SETUP (1 cycle): PSEL[idx]=1, PENABLE=0; PADDR/PWRITE/PWDATA/PSTRB/PPROT registered from the FIFO head.
//  Decode error (idx>=NUM_SLAVES): skip SETUP/ACCESS, no PSEL. Response: err=1, rdata=0.
//  ACCESS: PENABLE=1. Hold all address/control/data stable until PREADY=1.
//  On PREADY=1: capture PRDATA (reads) and PSLVERR into the response register, then go to IDLE.
//    PSEL and PENABLE are 0 the next cycle; rsp_valid=1 the next cycle.
//  Response register is single-entry and holds until rsp_valid&rsp_ready.
//    The next transfer starts no earlier than the cycle after the handshake.
//  Back-to-back transfers: minimum 3 cycles per transfer (SETUP, ACCESS, IDLE). No pipelining of SETUP into ACCESS.
//  Ordering: responses are strictly in command order.
// CONFIGURATION
//  APB_TIMEOUT_EN defined:
//    - An 8-bit-min counter is cleared on SETUP and increments each ACCESS cycle with PREADY=0.
//    - When it reaches TIMEOUT_CYCLES, the transfer is aborted: PSEL/PENABLE drop, response err=1, rdata=0.
//    - A PREADY arriving in the same cycle as the limit wins.
//  APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for PREADY.
// STRUCTURE
//  apb_bridge_pkg:
//    - typedef enum {IDLE,SETUP,ACCESS} apb_state_e
//    - cmd struct (write, addr, wdata, strb, prot)
//    - rsp struct (rdata, err)
//    - width helper functions
//  Sub-module apb_cmd_fifo: parametrised sync FIFO of cmd struct with full/empty flags and count.
//  Top file: FSM, decode, response register and timeout.
// TESTING
//  1. Write 0x0000_0010 data 0xDEADBEEF strb 0xF, PREADY=1 immediately
//     -> PSEL=0001 for 1 SETUP + 1 ACCESS cycle, PSTRB=0xF, rsp err=0.
//  2. Read 0x4000_0004 with PREADY low 3 ACCESS cycles, PRDATA=0x1234_5678
//     -> PSEL=0010, PADDR stable for 4 ACCESS cycles, rsp_rdata=0x12345678.
//  3. Push 5 cmds with rsp_ready=1, slave stalling
//     -> cmd_ready=0 after 4 queued; 5 responses arrive in order.
//  4. Read with PSLVERR=1 on completion, rsp_ready held 0 for 5 cycles
//     -> rsp_err=1, rdata=0, rsp held stable, no new SETUP until handshake.
//  5. NUM_SLAVES=3, address 0xC000_0000
//     -> no PSEL asserted, rsp err=1 within 2 cycles.
//  6. Assert PRESET during ACCESS
//     -> PSEL/PENABLE/rsp_valid 0 immediately, FIFO empty.
//     With APB_TIMEOUT_EN: PREADY never -> abort after 16 cycles, err=1.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared state encoding and width helpers for the APB master bridge
package apb_bridge_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction
  function automatic int slv_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1) > 8 ? $clog2(n + 1) : 8;
  endfunction
endpackage

// File: rtl/apb_cmd_fifo.sv
// apb_cmd_fifo: synchronous FIFO of command records with full/empty flags
module apb_cmd_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW:0] wp, rp;
  assign dout  = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full  = wp == {~rp[AW], rp[AW-1:0]};
  // storage write, no reset needed on the data array
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
  // read/write pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: APB4 master with command FIFO, slave decode and response register; APB_TIMEOUT_EN adds an ACCESS watchdog
module apb_master_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [NUM_SLAVES-1:0]   PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);
  localparam int SW = strb_w(DATA_WIDTH);
  localparam int SB = slv_bits(NUM_SLAVES);
  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         strb;
    logic [2:0]            prot;
  } cmd_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } rsp_t;
  apb_state_e state, state_nx;
  cmd_t cmd_in, head;
  rsp_t rsp;
  logic full, empty, ready_q, launch, dec_err, done, abort, xfer_end;
  logic [SB-1:0] idx;
  assign cmd_in    = {cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot};
  assign cmd_ready = ready_q & ~full;
  assign rsp_rdata = rsp.rdata;
  assign rsp_err   = rsp.err;
  assign idx       = NUM_SLAVES > 1 ? head.addr[ADDR_WIDTH-1 -: SB] : '0;
  assign dec_err   = NUM_SLAVES > 1 && 32'(idx) >= NUM_SLAVES;
  assign launch    = state == IDLE && !empty && (!rsp_valid || rsp_ready);
  assign done      = state == ACCESS && PREADY;
  assign xfer_end  = done | abort;
  apb_cmd_fifo #(.T(cmd_t), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk  (PCLK),
    .rst  (PRESET),
    .push (cmd_valid & cmd_ready),
    .pop  (launch),
    .din  (cmd_in),
    .dout (head),
    .full (full),
    .empty(empty)
  );
`ifdef APB_TIMEOUT_EN
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt;
  // counts stalled ACCESS cycles; a PREADY in the limit cycle still completes normally
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) tcnt <= '0;
    else if (state == SETUP) tcnt <= '0;
    else if (state == ACCESS && !PREADY) tcnt <= tcnt + 1'b1;
  assign abort = state == ACCESS && !PREADY && tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign abort = TIMEOUT_CYCLES < 0;
`endif
  // state register
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) state <= IDLE;
    else state <= state_nx;
  // next state: decode errors never leave IDLE, they answer directly
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (launch && !dec_err ? SETUP : IDLE) :
               state == SETUP ? ACCESS :
               xfer_end       ? IDLE : ACCESS;
  end
  // APB outputs and response register
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      ready_q   <= 1'b0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      rsp_valid <= 1'b0;
      rsp       <= '0;
    end else begin
      ready_q <= 1'b1;
      if (launch && !dec_err) begin
        PSEL   <= NUM_SLAVES'(1) << idx;
        PWRITE <= head.write;
        PADDR  <= head.addr;
        PWDATA <= head.wdata;
        PSTRB  <= head.write ? head.strb : '0;
        PPROT  <= head.prot;
      end
      if (state == SETUP) PENABLE <= 1'b1;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if (launch && dec_err) begin
        rsp_valid <= 1'b1;
        rsp       <= '{rdata: '0, err: 1'b1};
      end
      if (xfer_end) begin
        PSEL      <= '0;
        PENABLE   <= 1'b0;
        rsp_valid <= 1'b1;
        rsp.rdata <= done && !PWRITE && !PSLVERR ? PRDATA : '0;
        rsp.err   <= done ? PSLVERR : 1'b1;
      end
    end
endmodule
